// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, NZCV register, condition check, branch resolve, M-stage register.
// Define EXEC_MUL_EN to build the 4-cycle iterative multiplier (ALUControlE = 111).
module execute_cycle #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWriteE,
  input  logic          ALUSrcE,
  input  logic          MemWriteE,
  input  logic          ResultSrcE,
  input  logic          BranchE,
  input  logic          FlagWriteE,
  input  logic [1:0]    CondE,
  input  logic [2:0]    ALUControlE,
  input  logic [DW-1:0] RD1_E,
  input  logic [DW-1:0] RD2_E,
  input  logic [DW-1:0] Imm_Ext_E,
  input  logic [RW-1:0] RD_E,
  input  logic [DW-1:0] PCE,
  input  logic [DW-1:0] PCPlus4E,
  input  logic [1:0]    ForwardAE,
  input  logic [1:0]    ForwardBE,
  input  logic [DW-1:0] ResultW,
  output logic          PCSrcE,
  output logic [DW-1:0] PCTargetE,
  output logic          StallE,
  output logic          RegWriteM,
  output logic          MemWriteM,
  output logic          ResultSrcM,
  output logic [RW-1:0] RD_M,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] PCPlus4M,
  output logic [3:0]    FlagsM
);

  logic [DW-1:0] src_a, fwd_b, src_b, alu_result, mul_result;
  logic [DW:0]   sum_ext, diff_ext;
  logic          c_flag, v_flag, v_add, v_sub, slt;
  logic [3:0]    nzcv;
  logic          cond_pass;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  // Flags are checked against the register value, i.e. before this instruction's own update.
  always_comb begin
    case (CondE)
      2'b01:   cond_pass = nzcv[2];
      2'b10:   cond_pass = !nzcv[2];
      2'b11:   cond_pass = nzcv[3] != nzcv[0];
      default: cond_pass = 1'b1;
    endcase
  end

`ifdef EXEC_MUL_EN
  // state | meaning
  // IDLE  | no multiply; a passing MUL here captures operands and adds byte 0
  // MUL1  | add partial product of operand-B byte 1
  // MUL2  | add partial product of operand-B byte 2
  // MUL3  | add byte 3, product goes to ALUResultM, stall released
  typedef enum logic [1:0] {IDLE, MUL1, MUL2, MUL3} mul_state_t;
  mul_state_t    state, state_next;
  logic [DW-1:0] mul_a, mul_b, mul_acc, mul_sum;
  logic          mul_start;

  assign mul_start = (state == IDLE) && (ALUControlE == 3'b111) && cond_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
    end else begin
      state   <= state_next;
      mul_acc <= mul_sum;
      if (mul_start) begin
        mul_a <= src_a;
        mul_b <= src_b;
      end
    end
  end

  always_comb begin
    state_next = state;
    mul_sum    = '0;
    StallE     = 1'b0;
    case (state)
      IDLE: begin
        mul_sum = src_a * DW'(src_b[7:0]);
        if (mul_start) begin
          StallE     = 1'b1;
          state_next = MUL1;
        end
      end
      MUL1: begin
        mul_sum    = mul_acc + ((mul_a * DW'(mul_b[15:8])) << 8);
        StallE     = 1'b1;
        state_next = MUL2;
      end
      MUL2: begin
        mul_sum    = mul_acc + ((mul_a * DW'(mul_b[23:16])) << 16);
        StallE     = 1'b1;
        state_next = MUL3;
      end
      default: begin
        mul_sum    = mul_acc + ((mul_a * DW'(mul_b[31:24])) << 24);
        state_next = IDLE;
      end
    endcase
    mul_result = (state == MUL3) ? mul_sum : '0;
  end
`else
  assign StallE     = 1'b0;
  assign mul_result = '0;
`endif

  always_comb begin
    sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    diff_ext = {1'b0, src_a} - {1'b0, src_b};
    v_add    = (src_a[DW-1] == src_b[DW-1]) && (sum_ext[DW-1] != src_a[DW-1]);
    v_sub    = (src_a[DW-1] != src_b[DW-1]) && (diff_ext[DW-1] != src_a[DW-1]);
    slt      = diff_ext[DW-1] ^ v_sub;
    alu_result = '0;
    c_flag     = 1'b0;
    v_flag     = 1'b0;
    case (ALUControlE)
      3'b000: begin alu_result = sum_ext[DW-1:0]; c_flag = sum_ext[DW]; v_flag = v_add; end
      3'b001: begin alu_result = diff_ext[DW-1:0]; c_flag = !diff_ext[DW]; v_flag = v_sub; end
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: begin alu_result = {{(DW-1){1'b0}}, slt}; c_flag = !diff_ext[DW]; v_flag = v_sub; end
      3'b110: alu_result = src_b;
      default: alu_result = mul_result;
    endcase
  end

  assign PCSrcE    = BranchE & cond_pass;
  assign PCTargetE = PCE + Imm_Ext_E;
  assign FlagsM    = nzcv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzcv <= 4'b0000;
    end else if (FlagWriteE && cond_pass && !StallE) begin
      nzcv <= {alu_result[DW-1], alu_result == '0, c_flag, v_flag};
    end
  end

  // A stalled cycle leaves a bubble: control cleared, data fields held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (!StallE) begin
      RegWriteM  <= RegWriteE & cond_pass;
      MemWriteM  <= MemWriteE & cond_pass;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end else begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle; expected values are hand-computed constants.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, FlagWriteE;
  logic [1:0]  CondE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic [3:0]  FlagsM;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  execute_cycle #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .FlagsM(FlagsM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                    input logic fw, input logic [1:0] cond);
    ALUControlE = alu; RD1_E = a; RD2_E = b; FlagWriteE = fw; CondE = cond;
  endtask

  initial begin
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    FlagWriteE = 0; CondE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0;
    Imm_Ext_E = 0; RD_E = 0; PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0;
    ResultW = 0;
    #1;
    chk("rst_alu", ALUResultM, 32'h0);
    chk("rst_flags", {28'h0, FlagsM}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ADD overflow into sign bit
    RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h44;
    op(3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1, 2'b00);
    step();
    chk("add_res", ALUResultM, 32'h8000_0000);
    chk("add_flags", {28'h0, FlagsM}, 32'h9);
    chk("add_regw", {31'h0, RegWriteM}, 32'h1);
    chk("add_rd", {27'h0, RD_M}, 32'h3);
    chk("add_pc4", PCPlus4M, 32'h44);
    chk("add_wd", WriteDataM, 32'h1);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("arst_alu", ALUResultM, 32'h0);
    chk("arst_regw", {31'h0, RegWriteM}, 32'h0);
    chk("arst_rd", {27'h0, RD_M}, 32'h0);
    chk("arst_pc4", PCPlus4M, 32'h0);
    chk("arst_flags", {28'h0, FlagsM}, 32'h0);
    chk("arst_stall", {31'h0, StallE}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    op(3'b001, 32'd5, 32'd5, 1'b1, 2'b00);
    step();
    chk("sub_res", ALUResultM, 32'h0);
    chk("sub_flags", {28'h0, FlagsM}, 32'h6);

    RegWriteE = 0; BranchE = 1; ALUSrcE = 1; Imm_Ext_E = 32'h10; PCE = 32'h100;
    op(3'b000, 32'h0, 32'h0, 1'b0, 2'b01);
    #1;
    chk("br_eq", {31'h0, PCSrcE}, 32'h1);
    chk("br_tgt", PCTargetE, 32'h110);
    CondE = 2'b10; #1;
    chk("br_ne", {31'h0, PCSrcE}, 32'h0);
    CondE = 2'b11; #1;
    chk("br_lt", {31'h0, PCSrcE}, 32'h0);
    CondE = 2'b00; #1;
    chk("br_al", {31'h0, PCSrcE}, 32'h1);

    // failed condition: no writes, flags kept, data still latched
    BranchE = 0; ALUSrcE = 0; RegWriteE = 1; MemWriteE = 1;
    op(3'b000, 32'd1, 32'd1, 1'b1, 2'b10);
    step();
    chk("cf_regw", {31'h0, RegWriteM}, 32'h0);
    chk("cf_memw", {31'h0, MemWriteM}, 32'h0);
    chk("cf_flags", {28'h0, FlagsM}, 32'h6);
    chk("cf_alu", ALUResultM, 32'h2);

    MemWriteE = 0;
    op(3'b000, 32'h20, 32'h0, 1'b0, 2'b00);
    step();
    chk("fw_pre", ALUResultM, 32'h20);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h3;
    op(3'b001, 32'hDEAD, 32'hBEEF, 1'b0, 2'b00);
    step();
    chk("fw_res", ALUResultM, 32'h1D);
    chk("fw_wd", WriteDataM, 32'h3);
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    op(3'b000, 32'h100, 32'h23, 1'b0, 2'b00);
    step();
    chk("fw11_res", ALUResultM, 32'h123);
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    op(3'b101, 32'hFFFF_FFFF, 32'h1, 1'b1, 2'b00);
    step();
    chk("slt_res", ALUResultM, 32'h1);
    chk("slt_flags", {28'h0, FlagsM}, 32'h2);
    op(3'b001, 32'd1, 32'd2, 1'b1, 2'b00);
    step();
    chk("sub_neg_flags", {28'h0, FlagsM}, 32'h8);
    BranchE = 1; op(3'b000, 32'h0, 32'h0, 1'b0, 2'b11); #1;
    chk("br_lt_taken", {31'h0, PCSrcE}, 32'h1);
    BranchE = 0;

    op(3'b010, 32'hF0F0, 32'hFF00, 1'b0, 2'b00); step();
    chk("and", ALUResultM, 32'hF000);
    op(3'b011, 32'hF0F0, 32'hFF00, 1'b0, 2'b00); step();
    chk("orr", ALUResultM, 32'hFFF0);
    op(3'b100, 32'hF0F0, 32'hFF00, 1'b1, 2'b00); step();
    chk("xor", ALUResultM, 32'h0FF0);
    chk("xor_flags", {28'h0, FlagsM}, 32'h0);
    ALUSrcE = 1; Imm_Ext_E = 32'h1234;
    op(3'b110, 32'h5, 32'h6, 1'b0, 2'b00); step();
    chk("mov", ALUResultM, 32'h1234);

    Imm_Ext_E = 32'h10;
    op(3'b111, 32'h1234_5678, 32'h0, 1'b0, 2'b00);
`ifdef EXEC_MUL_EN
    #1;
    chk("mul_stall0", {31'h0, StallE}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mul_stall", {31'h0, StallE}, 32'h1);
      chk("mul_bubble", {31'h0, RegWriteM}, 32'h0);
    end
    step();
    chk("mul_release", {31'h0, StallE}, 32'h0);
    step();
    chk("mul_res", ALUResultM, 32'h2345_6780);
    chk("mul_regw", {31'h0, RegWriteM}, 32'h1);
    op(3'b111, 32'h1234_5678, 32'h0, 1'b0, 2'b01);
    #1;
    chk("mul_cf_nostall", {31'h0, StallE}, 32'h0);
`else
    #1;
    chk("mul_nostall", {31'h0, StallE}, 32'h0);
    step();
    chk("mul_res0", ALUResultM, 32'h0);
    chk("mul_regw", {31'h0, RegWriteM}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
